// File: rtl/bus2_pkg.sv
// Shared definitions for the bus-2 line sequencer: bus command codes, FSM states, sizing helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package bus2_pkg;

    // Command values carried on the 2-bit bus-2 command lines
    typedef enum logic [1:0] {
        C2_NOP        = 2'd0,
        C2_RESPONSE   = 2'd1,
        C2_READ_LINE  = 2'd2,
        C2_WRITE_LINE = 2'd3
    } c2_cmd_e;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_BEAT = 3'd1,
        ST_WR_WAIT = 3'd2,
        ST_RD_CMD  = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_RD_BEAT = 3'd5
    } state_e;

    // Number of bus beats needed to move one cache line
    function automatic int beats_of(input int line_bytes, input int data_bits);
        return (line_bytes * 8) / data_bits;
    endfunction

    // Counter width able to index n beats (at least one bit)
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus2_line_buffer.sv
// Line-wide shift register: parallel load then beat-out for writes, beat-in then parallel read for fills.
// Latency: load/shift take effect on the next rising edge; the shifted line is also offered combinationally.
// Backpressure: none; the sequencer decides when to load or shift.
module bus2_line_buffer #(
    parameter int LINE_W = 128,
    parameter int BEAT_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [LINE_W-1:0] load_dat_i,
    input  logic              shift_i,
    input  logic [BEAT_W-1:0] beat_i,
    output logic [BEAT_W-1:0] next_beat_o,
    output logic [LINE_W-1:0] line_shifted_o
);

    logic [LINE_W-1:0] line_q;
    logic [LINE_W-1:0] line_d;

    // Beats leave from the bottom and arrive at the top, so after a full
    // read burst beat 0 sits at the least significant end (little-endian line).
    assign line_shifted_o = {beat_i, line_q[LINE_W-1:BEAT_W]};

    // Beat that moves to the bottom on the next shift
    assign next_beat_o = line_q[2*BEAT_W-1:BEAT_W];

    // Load has priority; a grant never coincides with a shift
    always_comb begin
        line_d = line_q;
        if (load_i) begin
            line_d = load_dat_i;
        end else if (shift_i) begin
            line_d = line_shifted_o;
        end
    end

    // Line storage
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

endmodule

// File: rtl/bus2_line_sequencer.sv
// Arbitrates writeback vs fill line requests and runs each as a bus-2 burst (command, address, beats, response).
// Latency: grant combinational; write beats cycles 1..BEATS after grant, fill data valid BEATS cycles after response.
// Backpressure: requests are held off (no grant) while a burst is active; writeback wins ties.
// Optional feature macro BUS2_TIMEOUT_EN: response watchdog ending a stalled burst with ERR plus DONE.
module bus2_line_sequencer
    import bus2_pkg::*;
#(
    parameter int ADDR2_BUS_SIZE  = 14,
    parameter int DATA2_BUS_SIZE  = 16,
    parameter int CACHE_LINE_SIZE = 16
`ifdef BUS2_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES  = 255
`endif
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         wb_req_i,
    input  logic [ADDR2_BUS_SIZE-1:0]    wb_addr_i,
    input  logic [CACHE_LINE_SIZE*8-1:0] wb_data_i,
    output logic                         wb_gnt_o,
    output logic                         wb_done_o,
    input  logic                         fill_req_i,
    input  logic [ADDR2_BUS_SIZE-1:0]    fill_addr_i,
    output logic                         fill_gnt_o,
    output logic                         fill_done_o,
    output logic [CACHE_LINE_SIZE*8-1:0] fill_data_o,
    output logic [1:0]                   c2_out_o,
    output logic                         c2_oe_o,
    output logic [ADDR2_BUS_SIZE-1:0]    a2_out_o,
    output logic [DATA2_BUS_SIZE-1:0]    d2_out_o,
    output logic                         d2_oe_o,
    input  logic [1:0]                   c2_in_i,
    input  logic [DATA2_BUS_SIZE-1:0]    d2_in_i,
    output logic                         busy_o,
    output logic                         err_o
);

    localparam int LINE_W = CACHE_LINE_SIZE * 8;
    localparam int BEATS  = beats_of(CACHE_LINE_SIZE, DATA2_BUS_SIZE);
    localparam int CNT_W  = cnt_width(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      rsp;
    logic                      tmo_hit;
    logic                      tmo_exit;

    c2_cmd_e                   c2_out_q, c2_out_d;
    logic                      c2_oe_q, c2_oe_d;
    logic                      d2_oe_q, d2_oe_d;
    logic [DATA2_BUS_SIZE-1:0] d2_out_q, d2_out_d;
    logic [ADDR2_BUS_SIZE-1:0] a2_out_q, a2_out_d;
    logic                      wb_done_q, wb_done_d;
    logic                      fill_done_q, fill_done_d;
    logic                      err_q, err_d;
    logic                      busy_q, busy_d;
    logic [LINE_W-1:0]         fill_data_q, fill_data_d;

    logic                      buf_load;
    logic                      buf_shift;
    logic [DATA2_BUS_SIZE-1:0] buf_next_beat;
    logic [LINE_W-1:0]         buf_shifted;

    // Our own drive would read back as a command, so the resolved bus is only trusted while released
    assign rsp = !c2_oe_q && (c2_in_i == C2_RESPONSE);

    // Grants are only given from IDLE; evict before fill on a tie
    assign wb_gnt_o   = (state_q == ST_IDLE) && wb_req_i;
    assign fill_gnt_o = (state_q == ST_IDLE) && fill_req_i && !wb_req_i;

`ifdef BUS2_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;

    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counts response-wait cycles; it is zero whenever a wait state is entered
    always_comb begin
        tmo_d = '0;
        if ((state_q == ST_WR_WAIT || state_q == ST_RD_WAIT) && !rsp && !tmo_hit) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    // Watchdog register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Next-state and beat counter; the counter only wraps by leaving the beat state
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tmo_exit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (wb_gnt_o) begin
                    state_d = ST_WR_BEAT;
                end else if (fill_gnt_o) begin
                    state_d = ST_RD_CMD;
                end
            end
            ST_WR_BEAT: begin
                if (cnt_q == LAST_BEAT) begin
                    state_d = ST_WR_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WR_WAIT: begin
                if (rsp) begin
                    state_d = ST_IDLE;
                end else if (tmo_hit) begin
                    state_d  = ST_IDLE;
                    tmo_exit = 1'b1;
                end
            end
            ST_RD_CMD: begin
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                // The response cycle already carries beat 0
                if (rsp) begin
                    state_d = ST_RD_BEAT;
                    cnt_d   = CNT_W'(1);
                end else if (tmo_hit) begin
                    state_d  = ST_IDLE;
                    tmo_exit = 1'b1;
                end
            end
            ST_RD_BEAT: begin
                if (cnt_q == LAST_BEAT) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Line buffer: loaded on a writeback grant, shifted on every write beat and every received read beat
    assign buf_load  = wb_gnt_o;
    assign buf_shift = (state_q == ST_WR_BEAT) || (state_q == ST_RD_BEAT) ||
                       ((state_q == ST_RD_WAIT) && rsp);

    bus2_line_buffer #(
        .LINE_W (LINE_W),
        .BEAT_W (DATA2_BUS_SIZE)
    ) u_line_buffer (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .load_i         (buf_load),
        .load_dat_i     (wb_data_i),
        .shift_i        (buf_shift),
        .beat_i         (d2_in_i),
        .next_beat_o    (buf_next_beat),
        .line_shifted_o (buf_shifted)
    );

    // Output values for the next cycle, derived from the state being entered
    always_comb begin
        c2_out_d    = C2_NOP;
        c2_oe_d     = 1'b0;
        d2_oe_d     = 1'b0;
        d2_out_d    = '0;
        a2_out_d    = a2_out_q;
        if (wb_gnt_o) begin
            a2_out_d = wb_addr_i;
        end else if (fill_gnt_o) begin
            a2_out_d = fill_addr_i;
        end else if (state_d == ST_IDLE) begin
            a2_out_d = '0;
        end
        case (state_d)
            ST_WR_BEAT: begin
                c2_out_d = C2_WRITE_LINE;
                c2_oe_d  = 1'b1;
                d2_oe_d  = 1'b1;
                // First beat comes straight from the request, the rest from the buffer
                d2_out_d = (state_q == ST_IDLE) ? wb_data_i[DATA2_BUS_SIZE-1:0] : buf_next_beat;
            end
            ST_RD_CMD: begin
                c2_out_d = C2_READ_LINE;
                c2_oe_d  = 1'b1;
            end
            default: begin
            end
        endcase
        busy_d      = (state_d != ST_IDLE);
        wb_done_d   = (state_q == ST_WR_WAIT) && (state_d == ST_IDLE);
        fill_done_d = ((state_q == ST_RD_WAIT) || (state_q == ST_RD_BEAT)) && (state_d == ST_IDLE);
        err_d       = tmo_exit;
        // Only a completed read replaces the visible fill line; a timed-out read keeps the old one
        fill_data_d = fill_data_q;
        if ((state_q == ST_RD_BEAT) && (state_d == ST_IDLE)) begin
            fill_data_d = buf_shifted;
        end
    end

    // State, counter and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            c2_out_q    <= C2_NOP;
            c2_oe_q     <= 1'b0;
            d2_oe_q     <= 1'b0;
            d2_out_q    <= '0;
            a2_out_q    <= '0;
            wb_done_q   <= 1'b0;
            fill_done_q <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            fill_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            c2_out_q    <= c2_out_d;
            c2_oe_q     <= c2_oe_d;
            d2_oe_q     <= d2_oe_d;
            d2_out_q    <= d2_out_d;
            a2_out_q    <= a2_out_d;
            wb_done_q   <= wb_done_d;
            fill_done_q <= fill_done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            fill_data_q <= fill_data_d;
        end
    end

    assign c2_out_o    = c2_out_q;
    assign c2_oe_o     = c2_oe_q;
    assign d2_oe_o     = d2_oe_q;
    assign d2_out_o    = d2_out_q;
    assign a2_out_o    = a2_out_q;
    assign wb_done_o   = wb_done_q;
    assign fill_done_o = fill_done_q;
    assign err_o       = err_q;
    assign busy_o      = busy_q;
    assign fill_data_o = fill_data_q;

endmodule

// File: doc/bus2_line_sequencer.md
# bus2_line_sequencer

Memory-side controller between the cache core and bus 2. Arbitrates two line requesters (dirty-line writeback, line fill) and runs the selected transfer as a multi-beat burst: command, address, data beats, response wait. The cache core hands over a whole line through a valid/grant handshake and never touches bus-2 timing itself.

## Interface
- ADDR2_BUS_SIZE, 14: line address width (tag + set)
- DATA2_BUS_SIZE, 16: bus-2 data width in bits, multiple of 8
- CACHE_LINE_SIZE, 16: line size in bytes; BEATS = CACHE_LINE_SIZE*8/DATA2_BUS_SIZE (default 8)
- TIMEOUT_CYCLES, 255: response watchdog limit (only with the macro)
- CLK  in  1  clock, all state on rising edge
- RESET  in  1  asynchronous, active-low reset
- WB_REQ / WB_ADDR / WB_DATA  in  1 / ADDR2 / LINE*8  writeback request, line address, line bytes (byte k at [8k+7:8k])
- WB_GNT  out  1  request accepted this cycle
- WB_DONE  out  1  one-cycle pulse, writeback finished
- FILL_REQ / FILL_ADDR  in  1 / ADDR2  fill request, line address
- FILL_GNT, FILL_DONE  out  1  as for writeback
- FILL_DATA  out  LINE*8  received line; valid from FILL_DONE, held until next FILL_DONE
- C2_OUT, C2_OE  out  2, 1  driven command, drive enable
- A2_OUT  out  ADDR2  driven address
- D2_OUT, D2_OE  out  DATA2, 1  driven data, drive enable
- C2_IN, D2_IN  in  2, DATA2  resolved bus values
- BUSY  out  1  state != IDLE
- ERR  out  1  timeout pulse (tied 0 without the macro)

## Operation
- States: IDLE, WR_BEAT, WR_WAIT, RD_CMD, RD_WAIT, RD_BEAT.
- IDLE: GNT combinational = IDLE & REQ & arbitration win. WB beats FILL on simultaneous requests (evict before fill). Address/data captured on the granting edge; requester drops REQ after GNT.
- WR_BEAT: BEATS cycles, C2_OUT=C2_WRITE_LINE, A2_OUT=addr, C2_OE=D2_OE=1; beat k carries byte k*B+j at D2_OUT[8j+7:8j] (B = DATA2_BUS_SIZE/8, little-endian). Then release, enter WR_WAIT.
- WR_WAIT: on C2_IN==C2_RESPONSE -> IDLE, WB_DONE next cycle.
- RD_CMD: one cycle C2_OUT=C2_READ_LINE, A2_OUT=addr, C2_OE=1, D2_OE=0 -> RD_WAIT.
- RD_WAIT: on C2_IN==C2_RESPONSE capture beat 0 from D2_IN -> RD_BEAT; capture beats 1..BEATS-1 on following cycles -> IDLE, FILL_DONE pulse, FILL_DATA updated.
- C2_IN is ignored while C2_OE=1 (own drive) and in IDLE.
- Beat counter width clog2(BEATS); wraps only by state exit.
- Reset (any time, incl. mid-burst): state IDLE, all OE/GNT/DONE/ERR/BUSY 0, C2_OUT=C2_NOP, A2_OUT, D2_OUT, FILL_DATA, counters 0; aborted transfer produces no DONE.

## Timing
- Cycle 0 = GNT cycle.
- Write: beats in cycles 1..BEATS; WR_WAIT from BEATS+1; response earliest BEATS+1 at cycle R; WB_DONE in R+1; next GNT earliest R+1.
- Read: command cycle 1; RD_WAIT from 2; response at R>=2 carries beat 0; last beat R+BEATS-1; FILL_DONE in R+BEATS.
- All outputs registered except GNT.

## Configuration
- BUS2_TIMEOUT_EN defined: counter in WR_WAIT/RD_WAIT; after TIMEOUT_CYCLES cycles without response -> IDLE, pulse ERR together with the owning DONE; FILL_DATA not updated.
- Undefined: wait indefinitely, no counter, ERR=0.

## Structure
- bus2_pkg: C2_NOP=0, C2_RESPONSE=1, C2_READ_LINE=2, C2_WRITE_LINE=3 enum; state enum; BEATS and width helper constants.
- One sub-module: bus2_line_buffer (line shift register: parallel load + beat-out for writes, beat-in + parallel read for fills).

## Test plan
- Write: WB_ADDR=14'h0155, bytes 0x00..0x0F -> D2_OUT 16'h0100, 16'h0302 ... 16'h0F0E in cycles 1..8, C2_OUT=3; response at cycle 12 -> WB_DONE cycle 13.
- Read: FILL_ADDR=14'h02AA, response at cycle 5 with beats 16'hA1A0..16'hAFAE -> FILL_DONE cycle 13, FILL_DATA byte0=0xA0, byte15=0xAF.
- Simultaneous WB_REQ & FILL_REQ -> WB_GNT cycle 0, FILL_GNT 0; FILL_GNT in the WB_DONE cycle.
- C2_IN=C2_RESPONSE forced at cycle 4 of a write -> ignored, beats continue, WB_DONE only after later response.
- RESET low during read beat 3 -> all outputs reset immediately, no FILL_DONE, FILL_DATA=0, next request served normally.
- BUS2_TIMEOUT_EN, TIMEOUT_CYCLES=16, no response to write -> ERR and WB_DONE at cycle 25; without macro BUSY stays 1.
